// File: rtl/mem_access.sv
// MEM stage: loads/stores over a req/ack bus with alignment checks and timeout.
// Write-back triple to WB is registered; stallreq holds all earlier stages.
module mem_access #(
   parameter int BUS_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  ex_wd,
   input  logic        ex_wreg,
   input  logic [31:0] ex_wdata,
   input  logic [7:0]  ex_aluop,
   input  logic [31:0] ex_mem_addr,
   input  logic [31:0] ex_reg2,
   output logic        stallreq,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_sel,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack,
   output logic [4:0]  wb_wd,
   output logic        wb_wreg,
   output logic [31:0] wb_wdata,
   output logic        bus_err
);

   localparam logic [7:0] OP_LB  = 8'hE0;
   localparam logic [7:0] OP_LH  = 8'hE1;
   localparam logic [7:0] OP_LW  = 8'hE3;
   localparam logic [7:0] OP_LBU = 8'hE4;
   localparam logic [7:0] OP_LHU = 8'hE5;
   localparam logic [7:0] OP_SB  = 8'hE8;
   localparam logic [7:0] OP_SH  = 8'hE9;
   localparam logic [7:0] OP_SW  = 8'hEB;
   localparam logic [7:0] CNT_LAST = 8'(BUS_TIMEOUT - 1);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t      state;
   logic [7:0]  cnt;
   logic [7:0]  op_q;
   logic [1:0]  off_q;
   logic        ld_q;

   logic        is_load;
   logic        is_store;
   logic        is_byte;
   logic        is_half;
   logic        is_word;
   logic        is_mem;
   logic        misal;
   logic        timeout;
   logic [3:0]  sel_c;
   logic [31:0] wdata_c;
   logic [7:0]  byte_v;
   logic [15:0] half_v;
   logic [31:0] rd_ext;

   always_comb begin
      is_load  = 1'b0;
      is_store = 1'b0;
      is_byte  = 1'b0;
      is_half  = 1'b0;
      is_word  = 1'b0;
      case (ex_aluop)
         OP_LB, OP_LBU: begin is_load  = 1'b1; is_byte = 1'b1; end
         OP_LH, OP_LHU: begin is_load  = 1'b1; is_half = 1'b1; end
         OP_LW:         begin is_load  = 1'b1; is_word = 1'b1; end
         OP_SB:         begin is_store = 1'b1; is_byte = 1'b1; end
         OP_SH:         begin is_store = 1'b1; is_half = 1'b1; end
         OP_SW:         begin is_store = 1'b1; is_word = 1'b1; end
         default: ;
      endcase
   end

   assign is_mem  = is_load | is_store;
   assign misal   = (is_half & ex_mem_addr[0])
                  | (is_word & (ex_mem_addr[1:0] != 2'b00));
   assign timeout = (cnt == CNT_LAST);

   always_comb begin
      stallreq = 1'b0;
      if (rst) begin
         if (state == IDLE)
            stallreq = is_mem & ~misal;
         else
            stallreq = ~bus_ack & ~timeout;
      end
   end

   // Big-endian lanes: offset 0 is bits [31:24]
   always_comb begin
      sel_c   = 4'b1111;
      wdata_c = 32'h0;
      if (is_byte)
         sel_c = 4'b1000 >> ex_mem_addr[1:0];
      else if (is_half)
         sel_c = ex_mem_addr[1] ? 4'b0011 : 4'b1100;
      if (is_store) begin
         if (is_byte)      wdata_c = {4{ex_reg2[7:0]}};
         else if (is_half) wdata_c = {2{ex_reg2[15:0]}};
         else              wdata_c = ex_reg2;
      end
   end

   always_comb begin
      case (off_q)
         2'd0:    byte_v = bus_rdata[31:24];
         2'd1:    byte_v = bus_rdata[23:16];
         2'd2:    byte_v = bus_rdata[15:8];
         default: byte_v = bus_rdata[7:0];
      endcase
      half_v = off_q[1] ? bus_rdata[15:0] : bus_rdata[31:16];
      case (op_q)
         OP_LB:   rd_ext = {{24{byte_v[7]}}, byte_v};
         OP_LBU:  rd_ext = {24'h0, byte_v};
         OP_LH:   rd_ext = {{16{half_v[15]}}, half_v};
         OP_LHU:  rd_ext = {16'h0, half_v};
         OP_LW:   rd_ext = bus_rdata;
         default: rd_ext = 32'h0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= 8'h0;
         op_q      <= 8'h0;
         off_q     <= 2'b00;
         ld_q      <= 1'b0;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= 32'h0;
         bus_sel   <= 4'h0;
         bus_wdata <= 32'h0;
         wb_wd     <= 5'h0;
         wb_wreg   <= 1'b0;
         wb_wdata  <= 32'h0;
         bus_err   <= 1'b0;
      end else begin
         bus_err <= 1'b0;
         case (state)
            IDLE: begin
               if (!is_mem) begin
                  wb_wd    <= ex_wd;
                  wb_wreg  <= ex_wreg;
                  wb_wdata <= ex_wdata;
               end else if (misal) begin
                  wb_wd    <= ex_wd;
                  wb_wreg  <= 1'b0;
                  wb_wdata <= 32'h0;
                  bus_err  <= 1'b1;
               end else begin
                  bus_req   <= 1'b1;
                  bus_we    <= is_store;
                  bus_addr  <= {ex_mem_addr[31:2], 2'b00};
                  bus_sel   <= sel_c;
                  bus_wdata <= wdata_c;
                  wb_wreg   <= 1'b0;
                  cnt       <= 8'h0;
                  op_q      <= ex_aluop;
                  off_q     <= ex_mem_addr[1:0];
                  ld_q      <= is_load;
                  state     <= ACCESS;
               end
            end
            ACCESS: begin
               if (bus_ack) begin
                  bus_req  <= 1'b0;
                  wb_wd    <= ex_wd;
                  wb_wreg  <= ld_q & ex_wreg;
                  wb_wdata <= rd_ext;
                  state    <= IDLE;
               end else if (timeout) begin
                  bus_req <= 1'b0;
                  wb_wreg <= 1'b0;
                  bus_err <= 1'b1;
                  state   <= IDLE;
               end else begin
                  cnt     <= cnt + 8'd1;
                  wb_wreg <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: scoreboard of expected write-back results per access.
// A second instance with a short timeout covers the abort path.
module tb_mem_access;

   localparam logic [7:0] OP_NOP = 8'h25;
   localparam logic [7:0] OP_LB  = 8'hE0;
   localparam logic [7:0] OP_LH  = 8'hE1;
   localparam logic [7:0] OP_LW  = 8'hE3;
   localparam logic [7:0] OP_LBU = 8'hE4;
   localparam logic [7:0] OP_LHU = 8'hE5;
   localparam logic [7:0] OP_SB  = 8'hE8;
   localparam logic [7:0] OP_SH  = 8'hE9;

   typedef struct packed {
      logic [4:0]  wd;
      logic        wreg;
      logic [31:0] wdata;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [4:0]  ex_wd = '0;
   logic        ex_wreg = 1'b0;
   logic [31:0] ex_wdata = '0;
   logic [7:0]  ex_aluop = OP_NOP;
   logic [31:0] ex_mem_addr = '0;
   logic [31:0] ex_reg2 = '0;
   logic        stallreq;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_sel;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata = '0;
   logic        bus_ack = 1'b0;
   logic [4:0]  wb_wd;
   logic        wb_wreg;
   logic [31:0] wb_wdata;
   logic        bus_err;

   logic [7:0]  ex_aluop2 = 8'h00;
   logic        stallreq2;
   logic        bus_req2;
   logic        bus_we2;
   logic [31:0] bus_addr2;
   logic [3:0]  bus_sel2;
   logic [31:0] bus_wdata2;
   logic        bus_ack2 = 1'b0;
   logic [4:0]  wb_wd2;
   logic        wb_wreg2;
   logic [31:0] wb_wdata2;
   logic        bus_err2;

   int checks = 0;
   int failures = 0;
   exp_t sb[$];

   int          o_stalls;
   logic        o_req0;
   logic        o_req;
   logic        o_we;
   logic [31:0] o_addr;
   logic [3:0]  o_sel;
   logic [31:0] o_bwdata;
   exp_t        o_wb;

   mem_access dut (
      .clk(clk), .rst(rst),
      .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
      .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
      .stallreq(stallreq), .bus_req(bus_req), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_sel(bus_sel), .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata), .bus_ack(bus_ack),
      .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
      .bus_err(bus_err)
   );

   mem_access #(.BUS_TIMEOUT(4)) dut2 (
      .clk(clk), .rst(rst),
      .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
      .ex_aluop(ex_aluop2), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
      .stallreq(stallreq2), .bus_req(bus_req2), .bus_we(bus_we2),
      .bus_addr(bus_addr2), .bus_sel(bus_sel2), .bus_wdata(bus_wdata2),
      .bus_rdata(bus_rdata), .bus_ack(bus_ack2),
      .wb_wd(wb_wd2), .wb_wreg(wb_wreg2), .wb_wdata(wb_wdata2),
      .bus_err(bus_err2)
   );

   always #5 clk = ~clk;

   // Presents one op at a negedge and follows it until it leaves MEM.
   task automatic do_access(input logic [7:0] op, input logic [4:0] wd,
                            input logic [31:0] addr, input logic [31:0] reg2,
                            input logic [31:0] wdata, input int ack_at,
                            input logic [31:0] rdata);
      int cyc = 0;
      int i;
      ex_aluop    = op;
      ex_wd       = wd;
      ex_wreg     = 1'b1;
      ex_wdata    = wdata;
      ex_mem_addr = addr;
      ex_reg2     = reg2;
      bus_ack     = 1'b0;
      o_stalls    = 0;
      o_req       = 1'b0;
      o_req0      = bus_req;
      for (i = 0; i < 300; i++) begin
         if (bus_req) begin
            if (!o_req) begin
               o_req    = 1'b1;
               o_we     = bus_we;
               o_addr   = bus_addr;
               o_sel    = bus_sel;
               o_bwdata = bus_wdata;
            end
            if (cyc == ack_at) begin
               bus_ack   = 1'b1;
               bus_rdata = rdata;
            end
            cyc++;
         end
         #1;
         if (!stallreq) break;
         o_stalls++;
         @(posedge clk);
         @(negedge clk);
      end
      if (i == 300) begin
         checks++;
         failures++;
         $display("FAIL access_bound: stall never released after %0d cycles", i);
      end
      @(posedge clk);
      @(negedge clk);
      bus_ack  = 1'b0;
      o_wb     = '{wb_wd, wb_wreg, wb_wdata, bus_err};
      ex_aluop = OP_NOP;
      ex_wd    = 5'd0;
      ex_wreg  = 1'b0;
      ex_wdata = 32'h0;
   endtask

   task automatic test_reset();
      exp_t e;
      ex_aluop    = OP_LW;
      ex_mem_addr = 32'h100;
      repeat (2) @(negedge clk);
      checks++;
      if ({bus_req, bus_we, bus_addr, bus_sel, bus_wdata, bus_err} !== '0) begin
         failures++;
         $display("FAIL reset_bus: got %h want 0",
                  {bus_req, bus_we, bus_addr, bus_sel, bus_wdata, bus_err});
      end
      e = '0;
      checks++;
      if ({wb_wd, wb_wreg, wb_wdata, 1'b0} !== e) begin
         failures++;
         $display("FAIL reset_wb: got %h %b %h want 0", wb_wd, wb_wreg, wb_wdata);
      end
      checks++;
      if (stallreq !== 1'b0) begin
         failures++;
         $display("FAIL reset_stall: got %b want 0", stallreq);
      end
      ex_aluop = OP_NOP;
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_nonmem();
      exp_t e;
      sb.push_back('{5'd3, 1'b1, 32'h1234, 1'b0});
      do_access(OP_NOP, 5'd3, 32'h0, 32'h0, 32'h1234, 0, 32'h0);
      e = sb.pop_front();
      checks++;
      if (o_wb !== e) begin
         failures++;
         $display("FAIL nonmem_wb: got %h want %h", o_wb, e);
      end
      checks++;
      if (o_stalls !== 0 || o_req !== 1'b0) begin
         failures++;
         $display("FAIL nonmem_stall: stalls %0d req %b want 0 0", o_stalls, o_req);
      end
   endtask

   task automatic test_loads();
      exp_t e;
      sb.push_back('{5'd7, 1'b1, 32'hFFFFFF83, 1'b0});
      do_access(OP_LB, 5'd7, 32'h102, 32'h0, 32'h0, 3, 32'h11228344);
      e = sb.pop_front();
      checks++;
      if (o_wb !== e) begin
         failures++;
         $display("FAIL lb_wb: got %h want %h", o_wb, e);
      end
      checks++;
      if ({o_req, o_we, o_addr, o_sel, o_bwdata} !== {1'b1, 1'b0, 32'h100, 4'b0010, 32'h0}) begin
         failures++;
         $display("FAIL lb_bus: got %b %b %h %b %h want 1 0 100 0010 0",
                  o_req, o_we, o_addr, o_sel, o_bwdata);
      end
      checks++;
      if (o_stalls !== 4) begin
         failures++;
         $display("FAIL lb_stall: got %0d want 4", o_stalls);
      end

      sb.push_back('{5'd8, 1'b1, 32'h00000083, 1'b0});
      do_access(OP_LBU, 5'd8, 32'h102, 32'h0, 32'h0, 3, 32'h11228344);
      e = sb.pop_front();
      checks++;
      if (o_wb !== e) begin
         failures++;
         $display("FAIL lbu_wb: got %h want %h", o_wb, e);
      end

      sb.push_back('{5'd9, 1'b1, 32'h00008001, 1'b0});
      do_access(OP_LHU, 5'd9, 32'h102, 32'h0, 32'h0, 0, 32'hAAAA8001);
      e = sb.pop_front();
      checks++;
      if (o_wb !== e || o_sel !== 4'b0011) begin
         failures++;
         $display("FAIL lhu_wb: got %h sel %b want %h sel 0011", o_wb, o_sel, e);
      end

      sb.push_back('{5'd10, 1'b1, 32'hFFFF8001, 1'b0});
      do_access(OP_LH, 5'd10, 32'h100, 32'h0, 32'h0, 1, 32'h8001AAAA);
      e = sb.pop_front();
      checks++;
      if (o_wb !== e || o_sel !== 4'b1100) begin
         failures++;
         $display("FAIL lh_wb: got %h sel %b want %h sel 1100", o_wb, o_sel, e);
      end
   endtask

   task automatic test_stores();
      exp_t e;
      sb.push_back('{5'd4, 1'b0, 32'h0, 1'b0});
      do_access(OP_SH, 5'd4, 32'h202, 32'hDEADBEEF, 32'h0, 0, 32'h0);
      e = sb.pop_front();
      checks++;
      if (o_wb !== e) begin
         failures++;
         $display("FAIL sh_wb: got %h want %h", o_wb, e);
      end
      checks++;
      if ({o_we, o_addr, o_sel, o_bwdata} !== {1'b1, 32'h200, 4'b0011, 32'hBEEFBEEF}) begin
         failures++;
         $display("FAIL sh_bus: got %b %h %b %h want 1 200 0011 beefbeef",
                  o_we, o_addr, o_sel, o_bwdata);
      end

      sb.push_back('{5'd5, 1'b0, 32'h0, 1'b0});
      do_access(OP_SB, 5'd5, 32'h303, 32'h1234565A, 32'h0, 2, 32'h0);
      e = sb.pop_front();
      checks++;
      if ({o_we, o_addr, o_sel, o_bwdata} !== {1'b1, 32'h300, 4'b0001, 32'h5A5A5A5A}
          || o_wb !== e) begin
         failures++;
         $display("FAIL sb_bus: got %b %h %b %h wb %h want 1 300 0001 5a5a5a5a wb %h",
                  o_we, o_addr, o_sel, o_bwdata, o_wb, e);
      end
   endtask

   task automatic test_misaligned();
      exp_t e;
      sb.push_back('{5'd6, 1'b0, 32'h0, 1'b1});
      do_access(OP_LW, 5'd6, 32'h201, 32'h0, 32'h0, 0, 32'h0);
      e = sb.pop_front();
      checks++;
      if (o_wb !== e) begin
         failures++;
         $display("FAIL misal_wb: got %h want %h", o_wb, e);
      end
      checks++;
      if (o_req !== 1'b0 || o_stalls !== 0 || bus_req !== 1'b0) begin
         failures++;
         $display("FAIL misal_bus: req %b stalls %0d want 0 0", o_req, o_stalls);
      end
      @(negedge clk);
      checks++;
      if (bus_err !== 1'b0) begin
         failures++;
         $display("FAIL misal_pulse: bus_err %b want 0", bus_err);
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      sb.push_back('{5'd11, 1'b1, 32'h01020304, 1'b0});
      sb.push_back('{5'd12, 1'b1, 32'h00000004, 1'b1 ^ 1'b1});
      do_access(OP_LW, 5'd11, 32'h400, 32'h0, 32'h0, 0, 32'h01020304);
      e = sb.pop_front();
      checks++;
      if (o_wb !== e) begin
         failures++;
         $display("FAIL b2b_first: got %h want %h", o_wb, e);
      end
      do_access(OP_LBU, 5'd12, 32'h403, 32'h0, 32'h0, 0, 32'h01020304);
      e = sb.pop_front();
      checks++;
      if (o_req0 !== 1'b0 || o_wb !== e || o_stalls !== 1) begin
         failures++;
         $display("FAIL b2b_second: req0 %b wb %h stalls %0d want 0 %h 1",
                  o_req0, o_wb, o_stalls, e);
      end
   endtask

   task automatic test_timeout();
      int st = 0;
      int i;
      ex_aluop2   = OP_LW;
      ex_mem_addr = 32'h500;
      ex_wd       = 5'd13;
      ex_wreg     = 1'b1;
      for (i = 0; i < 20; i++) begin
         #1;
         if (!stallreq2) break;
         st++;
         @(posedge clk);
         @(negedge clk);
      end
      checks++;
      if (st !== 4) begin
         failures++;
         $display("FAIL timeout_stall: got %0d want 4", st);
      end
      @(posedge clk);
      @(negedge clk);
      ex_aluop2 = 8'h00;
      checks++;
      if ({bus_req2, bus_err2, wb_wreg2} !== 3'b010) begin
         failures++;
         $display("FAIL timeout_abort: req %b err %b wreg %b want 0 1 0",
                  bus_req2, bus_err2, wb_wreg2);
      end
      @(negedge clk);
      checks++;
      if (bus_err2 !== 1'b0) begin
         failures++;
         $display("FAIL timeout_pulse: bus_err %b want 0", bus_err2);
      end
   endtask

   task automatic test_reset_mid_access();
      exp_t e;
      ex_aluop    = OP_LW;
      ex_mem_addr = 32'h600;
      ex_wd       = 5'd14;
      ex_wreg     = 1'b1;
      bus_ack     = 1'b0;
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
      end
      checks++;
      if (bus_req !== 1'b1 || stallreq !== 1'b1) begin
         failures++;
         $display("FAIL rstmid_pre: req %b stall %b want 1 1", bus_req, stallreq);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({bus_req, wb_wreg, stallreq} !== 3'b000) begin
         failures++;
         $display("FAIL rstmid_drop: req %b wreg %b stall %b want 0 0 0",
                  bus_req, wb_wreg, stallreq);
      end
      @(negedge clk);
      rst = 1'b1;
      sb.push_back('{5'd14, 1'b1, 32'hCAFEF00D, 1'b0});
      do_access(OP_LW, 5'd14, 32'h600, 32'h0, 32'h0, 1, 32'hCAFEF00D);
      e = sb.pop_front();
      checks++;
      if (o_wb !== e || o_addr !== 32'h600 || o_stalls !== 2) begin
         failures++;
         $display("FAIL rstmid_after: wb %h addr %h stalls %0d want %h 600 2",
                  o_wb, o_addr, o_stalls, e);
      end
   endtask

   initial begin
      test_reset();
      test_nonmem();
      test_loads();
      test_stores();
      test_misaligned();
      test_back_to_back();
      repeat (2) @(negedge clk);
      test_timeout();
      test_reset_mid_access();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: run did not finish");
      $fatal(1);
   end

endmodule
